// File: rtl/uart_pkt_ctrl_pkg.sv
// Shared definitions for the UART packet controller: state encodings,
// error codes, the default frame marker and checksum/length helpers.
package uart_pkt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } pkt_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Running XOR checksum step.
  function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  // A LEN byte is legal when it is non-zero and not above the configured maximum.
  function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/uart_pkt_timer.sv
// Inter-byte idle timer: counts while enabled, restarts on clear, and
// signals expire during the cycle its count sits at TO_CYCLES-1.
module uart_pkt_timer #(
  parameter int unsigned TO_CYCLES = 17360
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority, wrap after the last value, hold when disabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Packet framer behind uart_rx: parses SYNC | LEN | PAYLOAD | CHK, streams
// payload bytes with their index and reports each frame good or bad.
// Define UART_PKT_TIMEOUT_EN to build in the inter-byte timeout (err_code 11);
// without it a partially received frame waits indefinitely.
module uart_pkt_ctrl
  import uart_pkt_ctrl_pkg::*;
#(
  parameter int unsigned BASE_FREQ     = 50_000_000,
  parameter int unsigned BAUDRATE      = 115_200,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pld_data,
  output logic       pld_valid,
  output logic [7:0] pld_idx,
  output logic       frame_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned CNT_PER_BIT = BASE_FREQ / BAUDRATE;
  localparam int unsigned TO_CYCLES   = TIMEOUT_BYTES * 32'd10 * CNT_PER_BIT;
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

  pkt_state_e state_q, state_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] pld_data_q, pld_data_d;
  logic [7:0] pld_idx_q, pld_idx_d;
  logic       pld_valid_q, pld_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       busy_q, busy_d;
  logic       timeout_s;

`ifdef UART_PKT_TIMEOUT_EN
  logic tmr_clear_s;
  logic tmr_expire_s;

  // Timer restarts on every received byte and stays parked while idle.
  assign tmr_clear_s = rx_valid | ~busy_q;

  uart_pkt_timer #(
    .TO_CYCLES(TO_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear_s),
    .enable (busy_q),
    .expire (tmr_expire_s)
  );

  assign timeout_s = tmr_expire_s;
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TO_CYCLES != 32'd0);
  assign timeout_s = 1'b0;
`endif

  // Frame FSM next-state and output computation; a received byte beats a timeout.
  always_comb begin
    state_d       = state_q;
    chk_d         = chk_q;
    len_d         = len_q;
    idx_d         = idx_q;
    pld_data_d    = pld_data_q;
    pld_idx_d     = pld_idx_q;
    err_code_d    = err_code_q;
    pld_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d       = ST_LEN;
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEN: begin
          if (len_legal(rx_data, MAX_LEN_B)) begin
            len_d   = rx_data;
            chk_d   = rx_data;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end else begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
        ST_PAYLOAD: begin
          pld_data_d  = rx_data;
          pld_idx_d   = idx_q;
          pld_valid_d = 1'b1;
          chk_d       = chk_next(chk_q, rx_data);
          idx_d       = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (rx_data == chk_q) begin
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TO;
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any frame in progress silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      chk_q         <= 8'd0;
      len_q         <= 8'd0;
      idx_q         <= 8'd0;
      pld_data_q    <= 8'd0;
      pld_idx_q     <= 8'd0;
      pld_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'b00;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      chk_q         <= chk_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      pld_data_q    <= pld_data_d;
      pld_idx_q     <= pld_idx_d;
      pld_valid_q   <= pld_valid_d;
      frame_start_q <= frame_start_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign pld_data    = pld_data_q;
  assign pld_valid   = pld_valid_q;
  assign pld_idx     = pld_idx_q;
  assign frame_start = frame_start_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: a table of byte/expected-output rows
// plus hand sequences for reset, maximum length and inter-byte timeout.
module tb_uart_pkt_ctrl;
  import uart_pkt_ctrl_pkg::*;

  localparam int TO_CYC = 17360;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic [7:0] pld_idx;
  logic       frame_start;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_pkt_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .pld_data    (pld_data),
    .pld_valid   (pld_valid),
    .pld_idx     (pld_idx),
    .frame_start (frame_start),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic       pv;
    logic [7:0] idx;
    logic [7:0] dat;
    logic       st;
    logic       ok;
    logic       er;
    logic [1:0] ec;
    logic       bz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] rx, input logic pv, input logic [7:0] idx,
                              input logic [7:0] dat, input logic st, input logic ok,
                              input logic er, input logic [1:0] ec, input logic bz);
    vec_t v;
    v.rx = rx; v.pv = pv; v.idx = idx; v.dat = dat; v.st = st;
    v.ok = ok; v.er = er; v.ec = ec; v.bz = bz;
    return v;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One byte strobe; returns 1 time unit after the edge that sampled it.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    check8({tag, " pld_valid"}, 8'(pld_valid), 8'(v.pv));
    check8({tag, " frame_start"}, 8'(frame_start), 8'(v.st));
    check8({tag, " frame_ok"}, 8'(frame_ok), 8'(v.ok));
    check8({tag, " frame_err"}, 8'(frame_err), 8'(v.er));
    check8({tag, " err_code"}, 8'(err_code), 8'(v.ec));
    check8({tag, " busy"}, 8'(busy), 8'(v.bz));
    if (v.pv) begin
      check8({tag, " pld_idx"}, pld_idx, v.idx);
      check8({tag, " pld_data"}, pld_data, v.dat);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, " pld_valid"}, 8'(pld_valid), 8'd0);
    check8({tag, " frame_start"}, 8'(frame_start), 8'd0);
    check8({tag, " frame_ok"}, 8'(frame_ok), 8'd0);
    check8({tag, " frame_err"}, 8'(frame_err), 8'd0);
    check8({tag, " err_code"}, 8'(err_code), 8'd0);
    check8({tag, " busy"}, 8'(busy), 8'd0);
    check8({tag, " pld_data"}, pld_data, 8'd0);
    check8({tag, " pld_idx"}, pld_idx, 8'd0);
  endtask

  // Good frame A5 03 11 22 33 03 with the err_code that should still be held.
  task automatic add_good_frame(input logic [1:0] ec);
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ec, 1'b1));
    tbl.push_back(mk(8'h03, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ec, 1'b1));
    tbl.push_back(mk(8'h11, 1'b1, 8'd0, 8'h11, 1'b0, 1'b0, 1'b0, ec, 1'b1));
    tbl.push_back(mk(8'h22, 1'b1, 8'd1, 8'h22, 1'b0, 1'b0, 1'b0, ec, 1'b1));
    tbl.push_back(mk(8'h33, 1'b1, 8'd2, 8'h33, 1'b0, 1'b0, 1'b0, ec, 1'b1));
    tbl.push_back(mk(8'h03, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, ec, 1'b0));
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] xs;
    logic       seen;
    int         first;

    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // Case 1: good frame
    add_good_frame(2'b00);
    // Case 2: bad checksum (expected 0x32, sent 0x00)
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1));
    tbl.push_back(mk(8'h02, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
    tbl.push_back(mk(8'h10, 1'b1, 8'd0, 8'h10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
    tbl.push_back(mk(8'h20, 1'b1, 8'd1, 8'h20, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
    tbl.push_back(mk(8'h00, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, ERR_CHK, 1'b0));
    // Case 3: LEN 0 and LEN 17
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ERR_CHK, 1'b1));
    tbl.push_back(mk(8'h00, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, ERR_LEN, 1'b0));
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h11, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, ERR_LEN, 1'b0));
    // Case 4: noise ignored, then a good frame
    tbl.push_back(mk(8'h00, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b0));
    tbl.push_back(mk(8'hFF, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b0));
    tbl.push_back(mk(8'h5A, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b0));
    add_good_frame(ERR_LEN);
    // LEN=1 frame: chk = 01^7E = 7F
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h01, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h7E, 1'b1, 8'd0, 8'h7E, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h7F, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, ERR_LEN, 1'b0));
    // SYNC as payload data: chk = 02^A5^00 = A7
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h02, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'hA5, 1'b1, 8'd0, 8'hA5, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h00, 1'b1, 8'd1, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'hA7, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, ERR_LEN, 1'b0));
    // SYNC as LEN (165 > 16) is a length error; then a checksum error sets 10 again
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, ERR_LEN, 1'b0));
    tbl.push_back(mk(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h01, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h40, 1'b1, 8'd0, 8'h40, 1'b0, 1'b0, 1'b0, ERR_LEN, 1'b1));
    tbl.push_back(mk(8'h40, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, ERR_CHK, 1'b0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table-driven byte stream
    foreach (tbl[i]) begin
      send(tbl[i].rx);
      check_row($sformatf("row%0d", i), tbl[i]);
    end

    // Pulses last a single cycle
    @(posedge clk);
    #1;
    check8("pulse width frame_err", 8'(frame_err), 8'd0);
    check8("idle busy", 8'(busy), 8'd0);

    // Maximum legal length (16)
    send(8'hA5);
    check8("len16 start", 8'(frame_start), 8'd1);
    send(8'h10);
    xs = 8'h10;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 7 + 1);
      send(b);
      xs = xs ^ b;
      check8($sformatf("len16 pv%0d", i), 8'(pld_valid), 8'd1);
      check8($sformatf("len16 idx%0d", i), pld_idx, 8'(i));
      check8($sformatf("len16 dat%0d", i), pld_data, b);
    end
    check8("len16 busy before chk", 8'(busy), 8'd1);
    send(xs);
    check8("len16 frame_ok", 8'(frame_ok), 8'd1);
    check8("len16 frame_err", 8'(frame_err), 8'd0);
    check8("len16 busy", 8'(busy), 8'd0);

    // Reset in the middle of a payload
    send(8'hA5);
    send(8'h02);
    send(8'h44);
    check8("pre-reset pld_valid", 8'(pld_valid), 8'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (frame_ok || frame_err || pld_valid || frame_start || busy) seen = 1'b1;
    end
    check8("post-reset quiet", 8'(seen), 8'd0);
    send(8'h55);
    check8("post-reset stray byte busy", 8'(busy), 8'd0);
    send(8'hA5);
    check8("post-reset start", 8'(frame_start), 8'd1);
    send(8'h01);
    send(8'h7E);
    check8("post-reset pld_idx", pld_idx, 8'd0);
    send(8'h7F);
    check8("post-reset frame_ok", 8'(frame_ok), 8'd1);

`ifdef UART_PKT_TIMEOUT_EN
    // Timeout fires exactly TO_CYC cycles after the last byte
    send(8'hA5);
    send(8'h02);
    send(8'h44);
    first = 0;
    for (int k = 1; k <= TO_CYC + 4; k++) begin
      @(posedge clk);
      #1;
      if (frame_err === 1'b1 && first == 0) first = k;
    end
    check_int("timeout latency", first, TO_CYC);
    check8("timeout err_code", 8'(err_code), 8'(ERR_TO));
    check8("timeout busy", 8'(busy), 8'd0);
    check8("timeout no ok", 8'(frame_ok), 8'd0);

    // A byte in the expiry cycle wins over the timeout
    send(8'hA5);
    send(8'h02);
    send(8'h44);
    repeat (TO_CYC - 1) @(posedge clk);
    send(8'h55);
    check8("race frame_err", 8'(frame_err), 8'd0);
    check8("race pld_valid", 8'(pld_valid), 8'd1);
    check8("race pld_idx", pld_idx, 8'd1);
    check8("race busy", 8'(busy), 8'd1);
    send(8'h13);
    check8("race frame_ok", 8'(frame_ok), 8'd1);
`else
    // Without the timer a partial frame waits indefinitely
    send(8'hA5);
    send(8'h02);
    send(8'h44);
    seen = 1'b0;
    for (int k = 1; k <= TO_CYC + 640; k++) begin
      @(posedge clk);
      #1;
      if (frame_err === 1'b1) seen = 1'b1;
    end
    check8("no-timeout frame_err", 8'(seen), 8'd0);
    check8("no-timeout busy", 8'(busy), 8'd1);
    send(8'h55);
    check8("no-timeout pld_idx", pld_idx, 8'd1);
    send(8'h13);
    check8("no-timeout frame_ok", 8'(frame_ok), 8'd1);
    check8("no-timeout err_code", 8'(err_code), 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
